profile_counter_bank: RTL and testbench
=======================================

PROFILE_COUNTER_BANK -- requirements
Module: profile_counter_bank

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each channel counter.
REQ-002 Parameter CHANNELS, default 4, number of independent counter channels (1..16).
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port enable  input  CHANNELS  per-channel count enable.
REQ-006 Port direction  input  CHANNELS  per-channel direction: 1 counts up, 0 counts down.
REQ-007 Port saturate  input  CHANNELS  per-channel mode: 1 saturates at bounds, 0 wraps.
REQ-008 Port loadValid  input  1  load request strobe.
REQ-009 Port loadChannel  input  clog2(CHANNELS) (minimum 1)  channel targeted by the load.
REQ-010 Port loadValue  input  WIDTH  value written on load.
REQ-011 Port clearFlags  input  CHANNELS  per-channel clear of sticky flags.
REQ-012 Port counterValues  output  CHANNELS*WIDTH  live counts; channel i in bits [i*WIDTH +: WIDTH].
REQ-013 Port overflowFlags  output  CHANNELS  sticky: bound crossed or hit while counting.
REQ-014 Port anyOverflow  output  1  OR of overflowFlags, registered.

Function
REQ-015 Each channel updates only on the rising clock edge; outputs are registered, with 1-cycle latency from input to output.
REQ-016 Per channel, priority order SHALL be: reset, then load (loadValid with loadChannel==i), then count (enable[i]=1), else hold.
REQ-017 Wrap mode: up from all-ones yields 0; down from 0 yields all-ones; overflowFlags[i] set in the same edge.
REQ-018 Saturate mode: up at all-ones holds all-ones; down at 0 holds 0; overflowFlags[i] set when a count is requested at the bound.
REQ-019 Load SHALL NOT set overflowFlags; load and count on the same channel in the same cycle: load wins, count is dropped.
REQ-020 loadChannel >= CHANNELS with loadValid=1 SHALL be ignored (no channel changes).
REQ-021 clearFlags[i] and a same-cycle overflow event on channel i: set wins (flag remains 1).
REQ-022 anyOverflow SHALL lag overflowFlags by exactly one cycle.
REQ-023 Channels SHALL be fully independent; activity on one never alters another.

Reset
REQ-024 While reset=1 at a clock edge: all counterValues, overflowFlags, anyOverflow and snapshot state go to 0.
REQ-025 Reset asserted mid-count or during load SHALL override all other inputs in that cycle.

Configuration
REQ-026 Macro PROFILE_COUNTER_BANK_SNAPSHOT_EN, when defined, adds ports snapshotReq (input 1), snapshotValues (output CHANNELS*WIDTH), and snapshotValid (output 1).
REQ-027 With the macro defined, snapshotReq=1 captures the post-update values of all channels at that edge atomically; snapshotValid pulses 1 for exactly one cycle after capture.
REQ-028 With the macro defined, snapshotValues holds until the next snapshotReq or reset.
REQ-029 Without the macro, these ports and their registers SHALL NOT exist and the remaining behaviour is identical.

Structure
REQ-030 Shared package profile_counter_pkg holds the mode encoding constants (MODE_WRAP=0, MODE_SATURATE=1) and the direction constants (DIR_DOWN=0, DIR_UP=1).
REQ-031 A single sub-module, profile_counter_channel (one counter plus its sticky flag), SHALL be instantiated CHANNELS times via generate; load decode, anyOverflow and snapshot logic live in the top.

Verification
REQ-032 WIDTH=8, ch0 up/wrap, load 0xFE, enable for 3 cycles -> values 0xFF, 0x00, 0x01; overflowFlags[0]=1 from the 0x00 cycle; anyOverflow=1 one cycle later.
REQ-033 ch1 down/saturate from 0x02, enable for 4 cycles -> values 0x01, 0x00, 0x00, 0x00; overflowFlags[1] set on the third edge.
REQ-034 loadValid to ch2 with value 0x55 and enable[2]=1 in the same cycle -> ch2=0x55; no increment; flag unchanged.
REQ-035 clearFlags[0] in the same cycle as a wrap on ch0 -> flag stays 1; clearFlags[0] alone next cycle -> flag 0.
REQ-036 Reset asserted mid-count on all channels -> all outputs 0 on the next edge; counting resumes from 0 after release.
REQ-037 SNAPSHOT_EN defined: all channels counting up, snapshotReq pulse at count 0x10 -> snapshotValues shows 0x11 per channel; snapshotValid high for one cycle; the value is held while the live counts continue.

Source files
------------

// File: rtl/profile_counter_pkg.sv
// Shared encodings for the profile counter bank: channel mode and count direction.
package profile_counter_pkg;

  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_SATURATE = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/profile_counter_channel.sv
// One profile counter channel: load/count/hold register plus its sticky overflow flag.
// With PROFILE_COUNTER_BANK_SNAPSHOT_EN defined, the post-update value is exported for snapshots.
module profile_counter_channel
  import profile_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  input  logic             saturate,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             clearFlag,
  output logic [WIDTH-1:0] count,
  output logic             overflowFlag
`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
  ,
  output logic [WIDTH-1:0] countNext
`endif
);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_evt;

  always_comb begin
    count_nxt = count;
    ovf_evt   = 1'b0;
    if (load) begin
      count_nxt = loadValue;
    end else if (enable) begin
      if (direction == DIR_UP) begin
        if (count == '1) begin
          ovf_evt   = 1'b1;
          count_nxt = (saturate == MODE_SATURATE) ? count : '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          ovf_evt   = 1'b1;
          count_nxt = (saturate == MODE_SATURATE) ? count : '1;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
    end
  end

  // A same-cycle overflow beats a clear so no event is ever lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      count        <= '0;
      overflowFlag <= 1'b0;
    end else begin
      count        <= count_nxt;
      overflowFlag <= ovf_evt | (overflowFlag & ~clearFlag);
    end
  end

`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
  assign countNext = count_nxt;
`endif

endmodule

// File: rtl/profile_counter_bank.sv
// Bank of independent profile counters with load decode and a registered overflow summary.
// Optional atomic snapshot of all channels when PROFILE_COUNTER_BANK_SNAPSHOT_EN is defined.
module profile_counter_bank
  import profile_counter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int LW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       direction,
  input  logic [CHANNELS-1:0]       saturate,
  input  logic                      loadValid,
  input  logic [LW-1:0]             loadChannel,
  input  logic [WIDTH-1:0]          loadValue,
  input  logic [CHANNELS-1:0]       clearFlags,
  output logic [CHANNELS*WIDTH-1:0] counterValues,
  output logic [CHANNELS-1:0]       overflowFlags,
  output logic                      anyOverflow
`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
  ,
  input  logic                      snapshotReq,
  output logic [CHANNELS*WIDTH-1:0] snapshotValues,
  output logic                      snapshotValid
`endif
);

`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
  logic [CHANNELS*WIDTH-1:0] next_values;
`endif

  // Out-of-range channel numbers never match any index, so such loads are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic load_hit;
    assign load_hit = loadValid && (loadChannel == LW'(i));

    profile_counter_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable[i]),
      .direction    (direction[i]),
      .saturate     (saturate[i]),
      .load         (load_hit),
      .loadValue    (loadValue),
      .clearFlag    (clearFlags[i]),
      .count        (counterValues[i*WIDTH +: WIDTH]),
      .overflowFlag (overflowFlags[i])
`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
      ,
      .countNext    (next_values[i*WIDTH +: WIDTH])
`endif
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      anyOverflow <= 1'b0;
    end else begin
      anyOverflow <= |overflowFlags;
    end
  end

`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      snapshotValues <= '0;
      snapshotValid  <= 1'b0;
    end else begin
      snapshotValid <= snapshotReq;
      if (snapshotReq) snapshotValues <= next_values;
    end
  end
`endif

endmodule

// File: tb/tb_profile_counter_bank.sv
// Directed self-checking bench for profile_counter_bank (WIDTH=8, CHANNELS=3).
// Snapshot checks are compiled in when PROFILE_COUNTER_BANK_SNAPSHOT_EN is defined.
module tb_profile_counter_bank;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam int LW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [CH-1:0]     enable;
  logic [CH-1:0]     direction;
  logic [CH-1:0]     saturate;
  logic              loadValid;
  logic [LW-1:0]     loadChannel;
  logic [W-1:0]      loadValue;
  logic [CH-1:0]     clearFlags;
  logic [CH*W-1:0]   counterValues;
  logic [CH-1:0]     overflowFlags;
  logic              anyOverflow;
`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
  logic              snapshotReq;
  logic [CH*W-1:0]   snapshotValues;
  logic              snapshotValid;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  profile_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .direction     (direction),
    .saturate      (saturate),
    .loadValid     (loadValid),
    .loadChannel   (loadChannel),
    .loadValue     (loadValue),
    .clearFlags    (clearFlags),
    .counterValues (counterValues),
    .overflowFlags (overflowFlags),
    .anyOverflow   (anyOverflow)
`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
    ,
    .snapshotReq    (snapshotReq),
    .snapshotValues (snapshotValues),
    .snapshotValid  (snapshotValid)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [CH*W-1:0] vals,
                           input logic [CH-1:0] flags, input logic any);
    chk({tag, ".values"}, 32'(counterValues), 32'(vals));
    chk({tag, ".flags"}, 32'(overflowFlags), 32'(flags));
    chk({tag, ".any"}, 32'(anyOverflow), 32'(any));
  endtask

  task automatic load(input logic [LW-1:0] ch, input logic [W-1:0] val);
    loadValid   = 1'b1;
    loadChannel = ch;
    loadValue   = val;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = '0;
    direction   = 3'b111;
    saturate    = 3'b000;
    loadValid   = 1'b0;
    loadChannel = '0;
    loadValue   = '0;
    clearFlags  = '0;
`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
    snapshotReq = 1'b0;
`endif
    tick();
    chk_state("reset", 24'h000000, 3'b000, 1'b0);
    reset = 1'b0;

    // ch0 up/wrap from 0xFE
    load(2'd0, 8'hFE);
    tick();
    chk_state("ld0_fe", 24'h0000FE, 3'b000, 1'b0);
    loadValid = 1'b0;
    enable    = 3'b001;
    tick(); chk_state("wrap_ff", 24'h0000FF, 3'b000, 1'b0);
    tick(); chk_state("wrap_00", 24'h000000, 3'b001, 1'b0);
    tick(); chk_state("wrap_01", 24'h000001, 3'b001, 1'b1);
    enable = '0;

    // ch1 down/saturate from 0x02
    direction = 3'b101;
    saturate  = 3'b010;
    load(2'd1, 8'h02);
    tick(); chk_state("ld1_02", 24'h000201, 3'b001, 1'b1);
    loadValid = 1'b0;
    enable    = 3'b010;
    tick(); chk_state("sat_01", 24'h000101, 3'b001, 1'b1);
    tick(); chk_state("sat_00a", 24'h000001, 3'b001, 1'b1);
    tick(); chk_state("sat_00b", 24'h000001, 3'b011, 1'b1);
    tick(); chk_state("sat_00c", 24'h000001, 3'b011, 1'b1);
    enable = '0;

    // load beats count on ch2
    load(2'd2, 8'h55);
    enable = 3'b100;
    tick(); chk_state("ld_wins", 24'h550001, 3'b011, 1'b1);
    loadValid = 1'b0;
    enable    = '0;

    // clear vs same-cycle wrap on ch0
    load(2'd0, 8'hFF);
    tick(); chk_state("ld0_ff", 24'h5500FF, 3'b011, 1'b1);
    loadValid  = 1'b0;
    enable     = 3'b001;
    clearFlags = 3'b001;
    tick(); chk_state("clr_vs_set", 24'h550000, 3'b011, 1'b1);
    enable = '0;
    tick(); chk_state("clr_alone", 24'h550000, 3'b010, 1'b1);
    clearFlags = '0;

    // out-of-range channel is ignored
    load(2'd3, 8'hAA);
    tick(); chk_state("ld_oob", 24'h550000, 3'b010, 1'b1);

    // ch2 down/wrap from 0
    load(2'd2, 8'h00);
    tick(); chk_state("ld2_00", 24'h000000, 3'b010, 1'b1);
    loadValid = 1'b0;
    direction = 3'b001;
    enable    = 3'b100;
    tick(); chk_state("dnwrap", 24'hFF0000, 3'b110, 1'b1);
    enable = '0;

    // ch0 up/saturate at all-ones
    saturate = 3'b011;
    load(2'd0, 8'hFF);
    tick(); chk_state("ld0_ff2", 24'hFF00FF, 3'b110, 1'b1);
    loadValid = 1'b0;
    enable    = 3'b001;
    tick(); chk_state("upsat", 24'hFF00FF, 3'b111, 1'b1);
    enable = '0;

    // anyOverflow lags flags by one cycle
    clearFlags = 3'b111;
    tick(); chk_state("clr_all", 24'hFF00FF, 3'b000, 1'b1);
    clearFlags = '0;
    tick(); chk_state("any_lag", 24'hFF00FF, 3'b000, 1'b0);

    // reset mid-count and during load
    direction = 3'b111;
    saturate  = 3'b000;
    enable    = 3'b111;
    tick(); chk_state("all_up", 24'h000100, 3'b101, 1'b0);
    reset = 1'b1;
    load(2'd1, 8'h77);
    tick(); chk_state("rst_mid", 24'h000000, 3'b000, 1'b0);
    reset     = 1'b0;
    loadValid = 1'b0;
    tick(); chk_state("resume1", 24'h010101, 3'b000, 1'b0);
    tick(); chk_state("resume2", 24'h020202, 3'b000, 1'b0);

`ifdef PROFILE_COUNTER_BANK_SNAPSHOT_EN
    for (int k = 0; k < 14; k++) tick();
    chk_state("pre_snap", 24'h101010, 3'b000, 1'b0);
    snapshotReq = 1'b1;
    tick();
    chk("snap_vals", 32'(snapshotValues), 32'h00111111);
    chk("snap_valid1", 32'(snapshotValid), 32'd1);
    chk("snap_live1", 32'(counterValues), 32'h00111111);
    snapshotReq = 1'b0;
    tick();
    chk("snap_valid0", 32'(snapshotValid), 32'd0);
    chk("snap_hold", 32'(snapshotValues), 32'h00111111);
    chk("snap_live2", 32'(counterValues), 32'h00121212);
`endif

    enable = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
